// File: rtl/pwm_gen.sv
// pwm_gen: glitch-free PWM timing stage fed by the PWM register file.
// The 16-bit register word carries duty in [7:0] and prescale in [15:8].
// Both are shadowed and only take effect at period boundaries.
// Optional feature macro: PWM_GEN_SOFT_START_EN. When it is defined, the
// effective duty ramps toward the target by at most one step per period
// and restarts from 0 on every enable.

module pwm_gen (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_pwm_reg,
    input  logic        i_en,
    output logic        o_pwm,
    output logic        o_period_start,
    output logic [7:0]  o_duty_act
);

    // The step counter covers 0..254, so a full period is 255 steps.
    localparam logic [7:0] LAST_STEP = 8'd254;

    logic [7:0] pre;
    logic [7:0] cnt;
    logic [7:0] duty_act;
    logic [7:0] presc_act;

    logic [7:0] reg_duty;
    logic [7:0] reg_presc;
    logic [7:0] duty_next;
    logic [7:0] duty_idle;
    logic       tick;
    logic       wrap;

    assign reg_duty  = i_pwm_reg[7:0];
    assign reg_presc = i_pwm_reg[15:8];

    // A step ends when the prescaler reaches the shadowed prescale.
    // The period ends on the final step's tick.
    assign tick = (pre == presc_act);
    assign wrap = tick && (cnt == LAST_STEP);

`ifdef PWM_GEN_SOFT_START_EN
    // Soft start: move the shadow duty one step toward the target per period.
    // The shadow duty parks at 0 while disabled.
    always_comb begin
        duty_next = duty_act;
        duty_idle = 8'd0;
        if (duty_act < reg_duty) begin
            duty_next = duty_act + 8'd1;
        end else if (duty_act > reg_duty) begin
            duty_next = duty_act - 8'd1;
        end
    end
`else
    // Direct mode: the shadow duty jumps straight to the register value.
    always_comb begin
        duty_next = reg_duty;
        duty_idle = reg_duty;
    end
`endif

    // Prescaler: count clocks within one step and restart on every tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre <= 8'd0;
        end else if (!i_en) begin
            pre <= 8'd0;
        end else if (tick) begin
            pre <= 8'd0;
        end else begin
            pre <= pre + 8'd1;
        end
    end

    // Step counter: advance once per tick and wrap after the final step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= 8'd0;
        end else if (!i_en) begin
            cnt <= 8'd0;
        end else if (tick) begin
            if (cnt == LAST_STEP) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Shadow registers: track the live word while idle, and latch it at each wrap while running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_act <= 8'd0;
            duty_act  <= 8'd0;
        end else if (!i_en) begin
            presc_act <= reg_presc;
            duty_act  <= duty_idle;
        end else if (wrap) begin
            presc_act <= reg_presc;
            duty_act  <= duty_next;
        end
    end

    // Registered outputs: compare the step against the shadow duty, and pulse on each wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pwm          <= 1'b0;
            o_period_start <= 1'b0;
        end else if (!i_en) begin
            o_pwm          <= 1'b0;
            o_period_start <= 1'b0;
        end else begin
            o_pwm          <= (cnt < duty_act);
            o_period_start <= wrap;
        end
    end

    assign o_duty_act = duty_act;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: self-checking bench for pwm_gen.
// A period-level reference model is scoreboarded against the DUT on every clock.
// The bench also runs table-driven period measurements and directed corner sequences.

module tb_pwm_gen;

    localparam int MAX_WAIT = 5000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_pwm_reg = 16'h0000;
    logic        i_en = 1'b1;
    logic        o_pwm;
    logic        o_period_start;
    logic [7:0]  o_duty_act;

    int n_compared = 0;
    int n_mismatched = 0;
    bit sb_on = 1'b0;

    typedef struct {
        logic [15:0] reg_word;
        int          exp_len;
        int          exp_high;
    } vec_t;

    vec_t vecs[6];

    pwm_gen dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_pwm_reg      (i_pwm_reg),
        .i_en           (i_en),
        .o_pwm          (o_pwm),
        .o_period_start (o_period_start),
        .o_duty_act     (o_duty_act)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: tracks the clock position within the period, not a prescaler and step counter.
    int m_t = 0;
    int m_p = 0;
    int m_d = 0;
    bit m_pwm = 1'b0;
    bit m_ps = 1'b0;

    // Evaluate the reference model on each edge, and clear it on asynchronous reset.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_t = 0; m_p = 0; m_d = 0; m_pwm = 1'b0; m_ps = 1'b0;
        end else if (!i_en) begin
            m_t   = 0;
            m_p   = int'(i_pwm_reg[15:8]);
`ifdef PWM_GEN_SOFT_START_EN
            m_d   = 0;
`else
            m_d   = int'(i_pwm_reg[7:0]);
`endif
            m_pwm = 1'b0;
            m_ps  = 1'b0;
        end else begin
            m_pwm = ((m_t / (m_p + 1)) < m_d);
            if (m_t == 255 * (m_p + 1) - 1) begin
                m_t  = 0;
                m_ps = 1'b1;
                m_p  = int'(i_pwm_reg[15:8]);
`ifdef PWM_GEN_SOFT_START_EN
                if (m_d < int'(i_pwm_reg[7:0])) m_d = m_d + 1;
                else if (m_d > int'(i_pwm_reg[7:0])) m_d = m_d - 1;
`else
                m_d  = int'(i_pwm_reg[7:0]);
`endif
            end else begin
                m_t  = m_t + 1;
                m_ps = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic flagTimeout(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: timed out after %0d clocks, expected an o_period_start pulse", name, MAX_WAIT);
    endtask

    // Compare every DUT output against the model on the falling edge.
    always @(negedge i_clk) begin
        if (sb_on) begin
            checkOutput("sb_pwm", o_pwm, m_pwm);
            checkOutput("sb_period_start", o_period_start, m_ps);
            checkOutput("sb_duty_act", o_duty_act, m_d);
        end
    end

    task automatic applyStimulus(input logic [15:0] reg_word, input logic en);
        i_pwm_reg = reg_word;
        i_en      = en;
    endtask

    task automatic step_clk();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_pulse(input string name, output int n);
        n = 0;
        do begin
            step_clk();
            n++;
        end while (!o_period_start && n < MAX_WAIT);
        if (!o_period_start) flagTimeout(name);
    endtask

    // Count clocks and high clocks up to and including the next pulse, with an optional mid-period write.
    task automatic measure_period(input string name, input int write_at, input logic [15:0] wval,
                                  output int len, output int high, output bit contiguous,
                                  output logic [7:0] d_before, output logic [7:0] d_pulse);
        bit seen_low;
        len = 0; high = 0; contiguous = 1'b1; seen_low = 1'b0;
        d_before = o_duty_act;
        do begin
            if (len == write_at) i_pwm_reg = wval;
            d_before = o_duty_act;
            step_clk();
            len++;
            if (o_pwm) begin
                high++;
                if (seen_low) contiguous = 1'b0;
            end else begin
                seen_low = 1'b1;
            end
        end while (!o_period_start && len < MAX_WAIT);
        d_pulse = o_duty_act;
        if (!o_period_start) flagTimeout(name);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n, len, high;
        bit contig;
        logic [7:0] d_before, d_pulse;

        vecs[0] = '{16'h0000, 255, 0};
        vecs[1] = '{16'h00FF, 255, 255};
        vecs[2] = '{16'h0180, 510, 256};
        vecs[3] = '{16'h0001, 255, 1};
        vecs[4] = '{16'h02FE, 765, 762};
        vecs[5] = '{16'h0340, 1020, 256};

        // Reset state, then the first period runs with P=0 and D=0.
        applyStimulus(16'h0000, 1'b1);
        repeat (3) step_clk();
        checkOutput("reset_pwm", o_pwm, 0);
        checkOutput("reset_period_start", o_period_start, 0);
        checkOutput("reset_duty_act", o_duty_act, 0);
        i_rst_n = 1'b1;
        sb_on = 1'b1;
        wait_pulse("first_pulse", n);
        checkOutput("first_pulse_clock", n, 255);

        // Table-driven steady-state periods.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].reg_word, 1'b1);
            wait_pulse("vec_load", n);
            measure_period("vec_measure", -1, 16'h0000, len, high, contig, d_before, d_pulse);
            checkOutput($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
            checkOutput($sformatf("vec%0d_contiguous", i), contig, 1);
`ifndef PWM_GEN_SOFT_START_EN
            checkOutput($sformatf("vec%0d_high", i), high, vecs[i].exp_high);
`endif
        end

`ifndef PWM_GEN_SOFT_START_EN
        // D=255 stays high across three wraps.
        applyStimulus(16'h00FF, 1'b1);
        wait_pulse("full_load", n);
        for (int k = 0; k < 3; k++) begin
            measure_period("full_measure", -1, 16'h0000, len, high, contig, d_before, d_pulse);
            checkOutput("full_len", len, 255);
            checkOutput("full_high", high, 255);
        end

        // A mid-period write is shadowed until the next wrap.
        applyStimulus(16'h0040, 1'b1);
        wait_pulse("shadow_load", n);
        measure_period("shadow_cur", 100, 16'h00C0, len, high, contig, d_before, d_pulse);
        checkOutput("shadow_cur_high", high, 64);
        checkOutput("shadow_duty_before_wrap", d_before, 8'h40);
        checkOutput("shadow_duty_at_wrap", d_pulse, 8'hC0);
        measure_period("shadow_next", -1, 16'h0000, len, high, contig, d_before, d_pulse);
        checkOutput("shadow_next_high", high, 192);
`endif

        // Disable for three clocks at step 50, then restart at step 0.
        applyStimulus(16'h0040, 1'b1);
        wait_pulse("dis_load", n);
        wait_pulse("dis_align", n);
        repeat (50) step_clk();
        i_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step_clk();
            checkOutput("dis_pwm", o_pwm, 0);
            checkOutput("dis_period_start", o_period_start, 0);
`ifdef PWM_GEN_SOFT_START_EN
            checkOutput("dis_duty_act", o_duty_act, 0);
`else
            checkOutput("dis_duty_act", o_duty_act, 8'h40);
`endif
        end
        i_en = 1'b1;
        measure_period("reen_measure", -1, 16'h0000, len, high, contig, d_before, d_pulse);
        checkOutput("reen_len", len, 255);
`ifdef PWM_GEN_SOFT_START_EN
        checkOutput("reen_high", high, 0);
`else
        checkOutput("reen_high", high, 64);
`endif

`ifdef PWM_GEN_SOFT_START_EN
        // Soft start ramps one step per wrap, then ramps back down.
        applyStimulus(16'h0005, 1'b0);
        repeat (2) step_clk();
        checkOutput("soft_idle_duty", o_duty_act, 0);
        i_en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            wait_pulse("soft_up", n);
            checkOutput($sformatf("soft_up_%0d", k), o_duty_act, (k < 5) ? k : 5);
        end
        i_pwm_reg = 16'h0003;
        wait_pulse("soft_dn1", n);
        checkOutput("soft_down_1", o_duty_act, 4);
        wait_pulse("soft_dn2", n);
        checkOutput("soft_down_2", o_duty_act, 3);
        wait_pulse("soft_dn3", n);
        checkOutput("soft_down_hold", o_duty_act, 3);
`endif

        // An asynchronous reset mid-period clears everything, and the restart uses P=0.
        applyStimulus(16'h0280, 1'b1);
        wait_pulse("arst_load", n);
        repeat (300) step_clk();
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("arst_pwm", o_pwm, 0);
        checkOutput("arst_duty_act", o_duty_act, 0);
        step_clk();
        i_rst_n = 1'b1;
        wait_pulse("arst_first", n);
        checkOutput("arst_first_pulse_clock", n, 255);

        // Random traffic checked by the scoreboard.
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                i_pwm_reg = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
            end else if (op <= 7) begin
                i_en = 1'b0;
                repeat ($urandom_range(1, 6)) step_clk();
                i_en = 1'b1;
            end else begin
                i_pwm_reg = ($urandom_range(0, 1) == 1) ? 16'h00FF : 16'h0100;
            end
            repeat ($urandom_range(1, 400)) step_clk();
        end

        sb_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
